// File: rtl/conv_encoder_k3.sv
// Rate-1/2 feed-forward convolutional encoder with valid/ready framing.
// Each frame is flushed with K-1 zero tail bits so the trellis ends in state 0.
module conv_encoder_k3 #(
  parameter int unsigned   K     = 3,
  parameter logic [K-1:0]  G0    = K'(7),
  parameter logic [K-1:0]  G1    = K'(5),
  parameter int unsigned   CNT_W = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             IN_BIT,
  input  logic             IN_VALID,
  input  logic             IN_LAST,
  output logic             IN_READY,
  output logic [1:0]       OUT_SYM,
  output logic             OUT_VALID,
  output logic             OUT_LAST,
  input  logic             OUT_READY,
  output logic             BUSY,
  output logic [CNT_W-1:0] SYM_COUNT
);

  localparam int unsigned   TW       = $clog2(K) + 1;
  localparam logic [TW-1:0] TAIL_LEN = TW'(K - 1);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  state_t        state, state_nxt;
  logic [K-2:0]  sr, sr_nxt;
  logic [TW-1:0] tail_cnt, tail_nxt;

  logic          le, in_fire, tail_step, load, enc_bit, sym_last;
  logic [K-1:0]  v;
  logic [K-1:0]  shifted;
  logic [1:0]    sym;

  // Datapath: encode window {b, SR[0], ..., SR[K-2]}; tail bits encode 0.
  always_comb begin
    le        = ~OUT_VALID | OUT_READY;
    in_fire   = IN_VALID & IN_READY;
    tail_step = le & (state == TAIL);
    load      = in_fire | tail_step;
    enc_bit   = (state == TAIL) ? 1'b0 : IN_BIT;
    v         = '0;
    v[K-1]    = enc_bit;
    for (int unsigned i = 0; i < K - 1; i++) begin
      v[K-2-i] = sr[i];
    end
    sym      = {^(G0 & v), ^(G1 & v)};
    shifted  = {sr, enc_bit};
    sym_last = (state == TAIL) && (tail_cnt == TW'(1));
  end

  // State register, shift register and the registered output stage.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= IDLE;
      sr        <= '0;
      tail_cnt  <= '0;
      OUT_SYM   <= '0;
      OUT_VALID <= 1'b0;
      OUT_LAST  <= 1'b0;
      SYM_COUNT <= '0;
    end else begin
      state    <= state_nxt;
      sr       <= sr_nxt;
      tail_cnt <= tail_nxt;
      if (le) begin
        OUT_VALID <= load;
        OUT_LAST  <= load & sym_last;
        if (load) begin
          OUT_SYM <= sym;
        end
      end
      if (OUT_VALID && OUT_READY) begin
        SYM_COUNT <= OUT_LAST ? '0 : SYM_COUNT + CNT_W'(1);
      end
    end
  end

  // Next-state logic; SR, state and tail counter only move on a symbol load.
  always_comb begin
    state_nxt = state;
    tail_nxt  = tail_cnt;
    sr_nxt    = load ? shifted[K-2:0] : sr;
    unique case (state)
      IDLE, DATA: begin
        if (in_fire) begin
          if (IN_LAST) begin
            state_nxt = TAIL;
            tail_nxt  = TAIL_LEN;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      TAIL: begin
        if (tail_step) begin
          tail_nxt = tail_cnt - TW'(1);
          if (tail_cnt == TW'(1)) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    IN_READY = le & (state != TAIL) & ~RESET;
    BUSY     = (state != IDLE) | OUT_VALID;
  end

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Scoreboard bench for conv_encoder_k3: directed (7,5) frames plus random
// frames on a K=3 and a K=7 (171,133) instance against a window model.
module tb_conv_encoder_k3;

  logic        CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  logic        RESET, IN_BIT, IN_VALID, IN_LAST, IN_READY;
  logic [1:0]  OUT_SYM;
  logic        OUT_VALID, OUT_LAST, OUT_READY, BUSY;
  logic [15:0] SYM_COUNT;
  logic        dir_ready, rnd_ready, rand_mode;
  assign OUT_READY = rand_mode ? rnd_ready : dir_ready;

  logic        in7_bit, in7_valid, in7_last, in7_ready;
  logic [1:0]  out7_sym;
  logic        out7_valid, out7_last, rnd7_ready, busy7;
  logic [15:0] cnt7;

  conv_encoder_k3 #(.K(3), .G0(3'b111), .G1(3'b101), .CNT_W(16)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .IN_BIT(IN_BIT), .IN_VALID(IN_VALID),
    .IN_LAST(IN_LAST), .IN_READY(IN_READY), .OUT_SYM(OUT_SYM),
    .OUT_VALID(OUT_VALID), .OUT_LAST(OUT_LAST), .OUT_READY(OUT_READY),
    .BUSY(BUSY), .SYM_COUNT(SYM_COUNT)
  );

  conv_encoder_k3 #(.K(7), .G0(7'o171), .G1(7'o133), .CNT_W(16)) dut7 (
    .CLOCK(CLOCK), .RESET(RESET), .IN_BIT(in7_bit), .IN_VALID(in7_valid),
    .IN_LAST(in7_last), .IN_READY(in7_ready), .OUT_SYM(out7_sym),
    .OUT_VALID(out7_valid), .OUT_LAST(out7_last), .OUT_READY(rnd7_ready),
    .BUSY(busy7), .SYM_COUNT(cnt7)
  );

  localparam logic [2:0] G0_3 = 3'b111;
  localparam logic [2:0] G1_3 = 3'b101;
  localparam logic [6:0] G0_7 = 7'o171;
  localparam logic [6:0] G1_7 = 7'o133;

  int          checks = 0;
  int          errors = 0;
  logic [2:0]  q3[$];
  logic [2:0]  q7[$];
  logic [1:0]  w3;
  logic [2:0]  v3;
  logic [5:0]  w7;
  logic [6:0]  v7;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Window model: w holds prior bits with the most recent at the MSB.
  task automatic model3_push(input logic b, input logic last);
    v3 = {b, w3};
    q3.push_back({^(G0_3 & v3), ^(G1_3 & v3), 1'b0});
    w3 = v3[2:1];
    if (last) begin
      for (int t = 0; t < 2; t++) begin
        v3 = {1'b0, w3};
        q3.push_back({^(G0_3 & v3), ^(G1_3 & v3), (t == 1)});
        w3 = v3[2:1];
      end
    end
  endtask

  task automatic model7_push(input logic b, input logic last);
    v7 = {b, w7};
    q7.push_back({^(G0_7 & v7), ^(G1_7 & v7), 1'b0});
    w7 = v7[6:1];
    if (last) begin
      for (int t = 0; t < 6; t++) begin
        v7 = {1'b0, w7};
        q7.push_back({^(G0_7 & v7), ^(G1_7 & v7), (t == 5)});
        w7 = v7[6:1];
      end
    end
  endtask

  task automatic drive(input logic b, input logic last, input logic use_model);
    logic ok;
    ok       = 1'b0;
    IN_VALID = 1'b1;
    IN_BIT   = b;
    IN_LAST  = last;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge CLOCK);
      if (IN_READY === 1'b1) begin
        if (use_model) model3_push(b, last);
        @(posedge CLOCK);
        #1;
        ok = 1'b1;
      end
    end
    if (!ok) fail_now("drive_timeout");
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge CLOCK);
      if (BUSY === 1'b0) ok = 1'b1;
    end
    if (!ok) fail_now("idle_timeout");
  endtask

  task automatic push_frame1011();
    q3.push_back(3'b110); q3.push_back(3'b100); q3.push_back(3'b000);
    q3.push_back(3'b010); q3.push_back(3'b010); q3.push_back(3'b111);
  endtask

  task automatic drive_frame1011();
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    IN_VALID = 1'b0;
  endtask

  // Monitor: pops the expectation whenever a symbol handshake is visible.
  initial begin
    logic [2:0] exp;
    forever begin
      @(negedge CLOCK);
      if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
        if (q3.size() == 0) fail_now("k3_unexpected_symbol");
        else begin
          exp = q3.pop_front();
          check("k3_sym_last", 32'({OUT_SYM, OUT_LAST}), 32'(exp));
        end
      end
      if (out7_valid === 1'b1 && rnd7_ready === 1'b1) begin
        if (q7.size() == 0) fail_now("k7_unexpected_symbol");
        else begin
          exp = q7.pop_front();
          check("k7_sym_last", 32'({out7_sym, out7_last}), 32'(exp));
        end
      end
    end
  end

  initial begin
    rnd_ready  = 1'b1;
    rnd7_ready = 1'b1;
    forever begin
      @(posedge CLOCK);
      #1;
      rnd_ready  = ($urandom_range(0, 3) != 0);
      rnd7_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog_expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    longint t0;
    logic   ok;
    RESET = 1'b1; IN_VALID = 1'b0; IN_BIT = 1'b0; IN_LAST = 1'b0;
    dir_ready = 1'b1; rand_mode = 1'b0;
    in7_valid = 1'b0; in7_bit = 1'b0; in7_last = 1'b0;
    w3 = '0; w7 = '0;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_out_last", 32'(OUT_LAST), 32'd0);
    check("rst_out_sym", 32'(OUT_SYM), 32'd0);
    check("rst_sym_count", 32'(SYM_COUNT), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_in_ready", 32'(IN_READY), 32'd0);
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    @(negedge CLOCK);
    check("post_rst_in_ready", 32'(IN_READY), 32'd1);
    @(posedge CLOCK); #1;

    // Frame 1,0,1,1 at full rate.
    push_frame1011();
    drive_frame1011();
    @(negedge CLOCK); check("t1_in_ready_tail_a", 32'(IN_READY), 32'd0);
    @(negedge CLOCK); check("t1_in_ready_tail_b", 32'(IN_READY), 32'd0);
    @(negedge CLOCK);
    check("t1_in_ready_back", 32'(IN_READY), 32'd1);
    check("t1_sym_count_5", 32'(SYM_COUNT), 32'd5);
    check("t1_out_last", 32'(OUT_LAST), 32'd1);
    @(negedge CLOCK);
    check("t1_sym_count_0", 32'(SYM_COUNT), 32'd0);
    check("t1_busy_low", 32'(BUSY), 32'd0);
    @(posedge CLOCK); #1;

    // Single-bit frame.
    q3.push_back(3'b110); q3.push_back(3'b100); q3.push_back(3'b111);
    drive(1'b1, 1'b1, 1'b0);
    IN_VALID = 1'b0;
    repeat (3) @(negedge CLOCK);
    check("t2_last_loaded", 32'(OUT_LAST), 32'd1);
    check("t2_busy_high", 32'(BUSY), 32'd1);
    @(negedge CLOCK);
    check("t2_busy_low", 32'(BUSY), 32'd0);
    check("t2_out_valid_low", 32'(OUT_VALID), 32'd0);
    @(posedge CLOCK); #1;

    // Backpressure after the first symbol.
    push_frame1011();
    drive(1'b1, 1'b0, 1'b0);
    dir_ready = 1'b0;
    IN_VALID = 1'b1; IN_BIT = 1'b0; IN_LAST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK);
      check("t3_hold_sym", 32'(OUT_SYM), 32'd3);
      check("t3_hold_valid", 32'(OUT_VALID), 32'd1);
      check("t3_in_ready_low", 32'(IN_READY), 32'd0);
      @(posedge CLOCK); #1;
    end
    dir_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    IN_VALID = 1'b0;
    wait_idle();
    @(posedge CLOCK); #1;

    // Back-to-back frames 1,1 and 0,1: eight symbols with no bubble.
    q3.push_back(3'b110); q3.push_back(3'b010); q3.push_back(3'b010); q3.push_back(3'b111);
    q3.push_back(3'b000); q3.push_back(3'b110); q3.push_back(3'b100); q3.push_back(3'b111);
    drive(1'b1, 1'b0, 1'b0);
    t0 = $time;
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    IN_VALID = 1'b0;
    wait_idle();
    check("t4_no_bubble_span", 32'($time - t0), 32'd84);
    @(posedge CLOCK); #1;

    // Reset after two bits of a frame.
    q3.push_back(3'b110); q3.push_back(3'b100);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    IN_VALID = 1'b0;
    RESET = 1'b1;
    @(negedge CLOCK);
    check("t5_in_ready_in_reset", 32'(IN_READY), 32'd0);
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    @(negedge CLOCK);
    check("t5_out_valid", 32'(OUT_VALID), 32'd0);
    check("t5_out_last", 32'(OUT_LAST), 32'd0);
    check("t5_out_sym", 32'(OUT_SYM), 32'd0);
    check("t5_sym_count", 32'(SYM_COUNT), 32'd0);
    check("t5_busy", 32'(BUSY), 32'd0);
    @(posedge CLOCK); #1;
    push_frame1011();
    drive_frame1011();
    wait_idle();
    @(posedge CLOCK); #1;

    // Random frames with random backpressure on both instances.
    rand_mode = 1'b1;
    w3 = '0;
    w7 = '0;
    fork
      begin
        for (int f = 0; f < 8; f++) begin
          int unsigned nb;
          nb = $urandom_range(1, 10);
          for (int unsigned i = 0; i < nb; i++) begin
            drive(1'($urandom_range(0, 1)), (i == nb - 1), 1'b1);
          end
          IN_VALID = 1'b0;
          if ($urandom_range(0, 1) != 0) begin
            @(posedge CLOCK); #1;
          end
        end
        wait_idle();
      end
      begin
        for (int f = 0; f < 6; f++) begin
          int unsigned nb;
          nb = $urandom_range(1, 12);
          for (int unsigned i = 0; i < nb; i++) begin
            in7_valid = 1'b1;
            in7_bit   = 1'($urandom_range(0, 1));
            in7_last  = (i == nb - 1);
            ok = 1'b0;
            for (int n = 0; n < 100 && !ok; n++) begin
              @(negedge CLOCK);
              if (in7_ready === 1'b1) begin
                model7_push(in7_bit, in7_last);
                @(posedge CLOCK); #1;
                ok = 1'b1;
              end
            end
            if (!ok) fail_now("k7_drive_timeout");
          end
          in7_valid = 1'b0;
        end
        ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
          @(negedge CLOCK);
          if (busy7 === 1'b0) ok = 1'b1;
        end
        if (!ok) fail_now("k7_idle_timeout");
      end
    join
    @(posedge CLOCK); #1;
    rand_mode = 1'b0;
    check("k3_queue_drained", 32'(q3.size()), 32'd0);
    check("k7_queue_drained", 32'(q7.size()), 32'd0);
    repeat (2) @(posedge CLOCK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
